// File: rtl/tsv_fault_scan.sv
// TSV loopback fault scan: drives each TSV high then low, samples the receive
// side after a settle time, and reports a faulty-TSV map for the FNS adders.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; previous result held
// S_DRV_HI | one-hot drive on TSV idx, sample expects receive = 1
// S_DRV_LO | inverted one-hot drive, sample expects receive = 0
// S_DONE   | one-cycle completion, done pulse, result valid
module tsv_fault_scan #(
  parameter int N_TSV      = 6,
  parameter int N_RED      = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_TSV-1:0]           test_rx,
  output logic [N_TSV-1:0]           test_drv,
  output logic                       busy,
  output logic                       done,
  output logic                       f_valid,
  output logic [N_TSV-1:0]           f_flag,
  output logic [$clog2(N_TSV+1)-1:0] fault_cnt,
  output logic                       unrepairable
);

  localparam int IDX_W  = (N_TSV > 1) ? $clog2(N_TSV) : 1;
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNT_W  = $clog2(N_TSV+1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRV_HI = 2'd1,
    S_DRV_LO = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCNT_W-1:0]  scnt_q, scnt_d;
  logic [N_TSV-1:0]   flag_q, flag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               unrep_q, unrep_d;
  logic               last_scnt;
  logic               last_idx;
  logic               mark;
  logic [N_TSV-1:0]   onehot;

  assign last_scnt = (scnt_q == SCNT_W'(SETTLE_CYC-1));
  assign last_idx  = (idx_q == IDX_W'(N_TSV-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      scnt_q  <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      unrep_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      unrep_q <= unrep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scnt_d  = scnt_q;
    flag_d  = flag_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    mark    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRV_HI;
          idx_d   = '0;
          scnt_d  = '0;
          flag_d  = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_DRV_HI, S_DRV_LO: begin
        // abort wins over a sample landing on the same edge
        if (abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (!last_scnt) begin
          scnt_d = scnt_q + SCNT_W'(1);
        end else begin
          scnt_d = '0;
          if (state_q == S_DRV_HI) begin
            mark    = ~test_rx[idx_q];
            state_d = S_DRV_LO;
          end else begin
            mark = test_rx[idx_q];
            if (!last_idx) begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_DRV_HI;
            end else begin
              state_d = S_DONE;
              valid_d = 1'b1;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // a TSV failing both phases is counted once
    if (mark) begin
      flag_d[idx_q] = 1'b1;
      if (!flag_q[idx_q]) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign unrep_d = (cnt_d > CNT_W'(N_RED));

  always_comb begin
    onehot   = N_TSV'(1) << idx_q;
    test_drv = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_DRV_HI: begin
        test_drv = onehot;
        busy     = 1'b1;
      end
      S_DRV_LO: begin
        test_drv = ~onehot;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign f_valid      = valid_q;
  assign f_flag       = flag_q;
  assign fault_cnt    = cnt_q;
  assign unrepairable = unrep_q;

endmodule
